alu_cmd_sequencer: RTL

- Upstream command front-end for the multi-cycle ALU (modes 0 mulu, 1 divu, 2 shift, 3 avg).
- Buffers tagged commands from the host in a small FIFO and issues them one at a time on the ALU's pulse-valid / done-ready interface.
- Captures each 64-bit result and presents it, with its tag and mode, on a valid/ready result port with backpressure.
- Only one command is in flight in the ALU at any time.

---
 rtl/alu_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Command front-end for the multi-cycle ALU (0 mulu, 1 divu,
//             2 shift, 3 avg). Tagged host commands are buffered in a small
//             FIFO and issued one at a time on the ALU pulse-valid/done-ready
//             interface. Each 64-bit result is captured and offered, with its
//             tag, mode and divide-by-zero flag, on a valid/ready result port.
//  Ports    : clk, rst                       clock, synchronous active-high reset
//             cmd_valid/cmd_ready            host command handshake
//             cmd_mode/cmd_a/cmd_b/cmd_tag   command payload
//             alu_valid                      one-cycle issue pulse to the ALU
//             alu_mode/alu_a/alu_b           operands, held from issue to capture
//             alu_ready/alu_out              ALU done indication and result
//             res_valid/res_ready            result handshake (backpressure)
//             res_data/res_tag/res_mode      captured result and its command info
//             res_dbz                        command was divu with B==0
//             busy                           FIFO non-empty or sequencer active
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // host command port
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  // ALU issue / completion port
  output logic             alu_valid,
  output logic [1:0]       alu_mode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic             alu_ready,
  input  logic [63:0]      alu_out,
  // result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_mode,
  output logic             res_dbz,
  // status
  output logic             busy
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

  typedef struct packed {
    logic             dbz;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
    logic [31:0]      a;
    logic [31:0]      b;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_SKIP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  cmd_t               fifo_mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]   count_q,  count_d;

  logic fifo_wr;
  logic fifo_pop;
  logic fifo_empty;
  cmd_t cmd_in;
  cmd_t fifo_head;

  assign cmd_ready  = (count_q != c_depth);
  assign fifo_empty = (count_q == '0);
  assign fifo_wr    = cmd_valid & cmd_ready;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // Divide-by-zero is flagged on the way in so the flag travels with the entry.
  always_comb begin
    cmd_in      = '0;
    cmd_in.dbz  = (cmd_mode == 2'd1) && (cmd_b == 32'd0);
    cmd_in.tag  = cmd_tag;
    cmd_in.mode = cmd_mode;
    cmd_in.a    = cmd_a;
    cmd_in.b    = cmd_b;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // --------------------------------------------------------------------------
  // Issue / capture sequencer
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [1:0]         alu_mode_q, alu_mode_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
  logic               pend_dbz_q, pend_dbz_d;
  logic               res_valid_q, res_valid_d;
  logic [63:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [1:0]         res_mode_q, res_mode_d;
  logic               res_dbz_q, res_dbz_d;

  always_comb begin
    state_d     = state_q;
    alu_mode_d  = alu_mode_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    pend_tag_d  = pend_tag_q;
    pend_dbz_d  = pend_dbz_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_mode_d  = res_mode_q;
    res_dbz_d   = res_dbz_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The head is loaded into the operand registers on the way into
        // ISSUE, so the operands are already stable while alu_valid pulses.
        if (!fifo_empty) begin
          alu_mode_d = fifo_head.mode;
          alu_a_d    = fifo_head.a;
          alu_b_d    = fifo_head.b;
          pend_tag_d = fifo_head.tag;
          pend_dbz_d = fifo_head.dbz;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        state_d  = ST_SKIP;
      end
      ST_SKIP: begin
        // The ALU still shows its idle ready here; it must not be taken as done.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_ready) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_out;
          res_tag_d   = pend_tag_q;
          res_mode_d  = alu_mode_q;
          res_dbz_d   = pend_dbz_q;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // One idle cycle so the ALU settles before the next issue.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      pend_tag_q  <= '0;
      pend_dbz_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_mode_q  <= '0;
      res_dbz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_mode_q  <= alu_mode_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      pend_tag_q  <= pend_tag_d;
      pend_dbz_q  <= pend_dbz_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_mode_q  <= res_mode_d;
      res_dbz_q   <= res_dbz_d;
    end
  end

  assign alu_valid = (state_q == ST_ISSUE);
  assign alu_mode  = alu_mode_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_mode  = res_mode_q;
  assign res_dbz   = res_dbz_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire
